// File: rtl/sdc_controller_regs.sv
// Byte-addressed control/status register bank for the SD-card controller:
// 32 x 32-bit registers behind an 8-bit synchronous-write / combinational-read port.
module sdc_controller_regs (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] addr,
  input  logic [7:0] data_in,
  input  logic       we,
  output logic [7:0] data_out
);

  // Writable bits per register; read-only and reserved slots are all zero,
  // so their storage only ever holds the reset value.
  function automatic logic [31:0] reg_wmask(input logic [4:0] idx);
    case (idx)
      5'd0, 5'd2, 5'd3,
      5'd4, 5'd5, 5'd24: reg_wmask = 32'hFFFF_FFFF;
      5'd1:              reg_wmask = 32'h0000_3FFF;
      5'd6, 5'd8:        reg_wmask = 32'h00FF_FFFF;
      5'd7:              reg_wmask = 32'h0000_0003;
      5'd9:              reg_wmask = 32'h0000_00FF;
      5'd10:             reg_wmask = 32'h0000_0001;
      5'd13, 5'd14:      reg_wmask = 32'h0000_001F;
      5'd15, 5'd16:      reg_wmask = 32'h0000_0007;
      5'd17:             reg_wmask = 32'h0000_0FFF;
      5'd18:             reg_wmask = 32'h0000_FFFF;
      default:           reg_wmask = 32'h0000_0000;
    endcase
  endfunction

  function automatic logic [31:0] reg_reset(input logic [4:0] idx);
    case (idx)
      5'd17:   reg_reset = 32'h0000_01FF;
      5'd31:   reg_reset = 32'h0001_5344;
      default: reg_reset = 32'h0000_0000;
    endcase
  endfunction

  logic [31:0] regs_r [0:31];
  logic [4:0]  sel_s;
  logic [31:0] lane_mask_s;
  logic [31:0] wr_word_s;
  logic [31:0] rd_word_s;

  assign sel_s = addr[6:2];

  // Merge the incoming byte into the selected register, one lane only.
  always_comb begin
    lane_mask_s = 32'h0000_0000;
    case (addr[1:0])
      2'd0:    lane_mask_s = 32'h0000_00FF;
      2'd1:    lane_mask_s = 32'h0000_FF00;
      2'd2:    lane_mask_s = 32'h00FF_0000;
      2'd3:    lane_mask_s = 32'hFF00_0000;
      default: lane_mask_s = 32'h0000_0000;
    endcase
    wr_word_s = (regs_r[sel_s] & ~(lane_mask_s & reg_wmask(sel_s)))
              | ({4{data_in}} & lane_mask_s & reg_wmask(sel_s));
  end

  // Register storage with asynchronous reset to per-register defaults.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        regs_r[i] <= reg_reset(5'(i));
      end
    end else if (we) begin
      regs_r[sel_s] <= wr_word_s;
    end
  end

  // Combinational byte read of the addressed lane.
  always_comb begin
    rd_word_s = regs_r[sel_s];
    case (addr[1:0])
      2'd0:    data_out = rd_word_s[7:0];
      2'd1:    data_out = rd_word_s[15:8];
      2'd2:    data_out = rd_word_s[23:16];
      2'd3:    data_out = rd_word_s[31:24];
      default: data_out = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_sdc_controller_regs.sv
// Directed self-checking bench for sdc_controller_regs.
module tb_sdc_controller_regs;

  logic       clk;
  logic       rst;
  logic [6:0] addr;
  logic [7:0] data_in;
  logic       we;
  logic [7:0] data_out;

  int cmp_count;
  int err_count;

  sdc_controller_regs dut (
    .clk      (clk),
    .rst      (rst),
    .addr     (addr),
    .data_in  (data_in),
    .we       (we),
    .data_out (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_write(input logic [6:0] a, input logic [7:0] d);
    @(negedge clk);
    addr = a; data_in = d; we = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  task automatic read_at(input logic [6:0] a, output logic [7:0] d);
    addr = a;
    #1;
    d = data_out;
  endtask

  task automatic test_reset;
    logic [7:0] got, exp;
    for (int i = 0; i < 128; i++) begin
      case (i)
        8'h44:   exp = 8'hFF;
        8'h45:   exp = 8'h01;
        8'h7C:   exp = 8'h44;
        8'h7D:   exp = 8'h53;
        8'h7E:   exp = 8'h01;
        default: exp = 8'h00;
      endcase
      read_at(7'(i), got);
      cmp_count++;
      if (got !== exp) begin
        err_count++;
        $display("FAIL reset_read addr=0x%02h got=0x%02h exp=0x%02h", i, got, exp);
      end
    end
  endtask

  task automatic test_byte_lanes;
    logic [7:0] got;
    logic [7:0] exp [0:3];
    exp[0] = 8'hAA; exp[1] = 8'h00; exp[2] = 8'h00; exp[3] = 8'h55;
    do_write(7'h00, 8'hAA);
    do_write(7'h03, 8'h55);
    for (int i = 0; i < 4; i++) begin
      read_at(7'(i), got);
      cmp_count++;
      if (got !== exp[i]) begin
        err_count++;
        $display("FAIL byte_lane addr=0x%02h got=0x%02h exp=0x%02h", i, got, exp[i]);
      end
    end
  endtask

  task automatic test_addr_no_side_effect;
    logic [7:0] got;
    @(negedge clk);
    addr = 7'h04; data_in = 8'hC3; we = 1'b0;
    @(negedge clk);
    addr = 7'h05;
    @(negedge clk);
    do_write(7'h05, 8'h35);
    read_at(7'h05, got);
    cmp_count++;
    if (got !== 8'h35) begin
      err_count++;
      $display("FAIL cmd_lane1 got=0x%02h exp=0x35", got);
    end
    read_at(7'h04, got);
    cmp_count++;
    if (got !== 8'h00) begin
      err_count++;
      $display("FAIL cmd_lane0_untouched got=0x%02h exp=0x00", got);
    end
  endtask

  task automatic test_masking;
    logic [7:0] got;
    do_write(7'h05, 8'hFF);
    do_write(7'h45, 8'hFF);
    do_write(7'h25, 8'hFF);
    do_write(7'h1C, 8'hFF);
    read_at(7'h05, got);
    cmp_count++;
    if (got !== 8'h3F) begin
      err_count++;
      $display("FAIL mask_command got=0x%02h exp=0x3F", got);
    end
    read_at(7'h45, got);
    cmp_count++;
    if (got !== 8'h0F) begin
      err_count++;
      $display("FAIL mask_block_size got=0x%02h exp=0x0F", got);
    end
    read_at(7'h44, got);
    cmp_count++;
    if (got !== 8'hFF) begin
      err_count++;
      $display("FAIL block_size_lane0 got=0x%02h exp=0xFF", got);
    end
    read_at(7'h25, got);
    cmp_count++;
    if (got !== 8'h00) begin
      err_count++;
      $display("FAIL mask_clkdiv_lane1 got=0x%02h exp=0x00", got);
    end
    read_at(7'h1C, got);
    cmp_count++;
    if (got !== 8'h03) begin
      err_count++;
      $display("FAIL mask_control got=0x%02h exp=0x03", got);
    end
  endtask

  task automatic test_ro_reserved;
    logic [7:0] got;
    do_write(7'h38, 8'h1B);
    do_write(7'h7C, 8'h1B);
    do_write(7'h50, 8'h11);
    read_at(7'h38, got);
    cmp_count++;
    if (got !== 8'h1B) begin
      err_count++;
      $display("FAIL cmd_iser got=0x%02h exp=0x1B", got);
    end
    read_at(7'h7C, got);
    cmp_count++;
    if (got !== 8'h44) begin
      err_count++;
      $display("FAIL version_ro got=0x%02h exp=0x44", got);
    end
    read_at(7'h50, got);
    cmp_count++;
    if (got !== 8'h00) begin
      err_count++;
      $display("FAIL reserved got=0x%02h exp=0x00", got);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] got;
    // Same-cycle read/write: old value before the edge, new after.
    @(negedge clk);
    addr = 7'h20; data_in = 8'h77; we = 1'b1;
    #1;
    cmp_count++;
    if (data_out !== 8'h00) begin
      err_count++;
      $display("FAIL rw_before_edge got=0x%02h exp=0x00", data_out);
    end
    @(posedge clk);
    #1;
    cmp_count++;
    if (data_out !== 8'h77) begin
      err_count++;
      $display("FAIL rw_after_edge got=0x%02h exp=0x77", data_out);
    end
    // Held we repeats the same write idempotently.
    @(negedge clk);
    addr = 7'h62; data_in = 8'hC5;
    repeat (3) @(posedge clk);
    #1;
    we = 1'b0;
    read_at(7'h62, got);
    cmp_count++;
    if (got !== 8'hC5) begin
      err_count++;
      $display("FAIL held_we got=0x%02h exp=0xC5", got);
    end
  endtask

  task automatic test_async_reset;
    logic [7:0] got;
    @(posedge clk);
    #2;
    rst = 1'b1;
    read_at(7'h00, got);
    cmp_count++;
    if (got !== 8'h00) begin
      err_count++;
      $display("FAIL async_rst_argument got=0x%02h exp=0x00", got);
    end
    read_at(7'h45, got);
    cmp_count++;
    if (got !== 8'h01) begin
      err_count++;
      $display("FAIL async_rst_block_size got=0x%02h exp=0x01", got);
    end
    read_at(7'h38, got);
    cmp_count++;
    if (got !== 8'h00) begin
      err_count++;
      $display("FAIL async_rst_cmd_iser got=0x%02h exp=0x00", got);
    end
    // Writes attempted while reset is held are lost.
    addr = 7'h00; data_in = 8'h5A; we = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    cmp_count++;
    if (data_out !== 8'h00) begin
      err_count++;
      $display("FAIL write_during_rst got=0x%02h exp=0x00", data_out);
    end
    // Release mid-cycle with we still high: next edge writes.
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    cmp_count++;
    if (data_out !== 8'h00) begin
      err_count++;
      $display("FAIL rst_release_no_write got=0x%02h exp=0x00", data_out);
    end
    @(posedge clk);
    #1;
    we = 1'b0;
    cmp_count++;
    if (data_out !== 8'h5A) begin
      err_count++;
      $display("FAIL write_after_rst got=0x%02h exp=0x5A", data_out);
    end
  endtask

  initial begin
    cmp_count = 0;
    err_count = 0;
    rst = 1'b1;
    addr = 7'h00;
    data_in = 8'h00;
    we = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    rst = 1'b0;
    test_reset();
    test_byte_lanes();
    test_addr_no_side_effect();
    test_masking();
    test_ro_reserved();
    test_back_to_back();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
    $finish;
  end

endmodule
